// File: rtl/audiosystem_disp_pio_pkg.sv
// Shared register map constants and address decode for the display PIO bank.
package audiosystem_disp_pio_pkg;

  localparam logic [3:0] ADDR_MASK  = 4'd8;
  localparam logic [3:0] ADDR_CTRL  = 4'd9;
  localparam logic [3:0] ADDR_PHASE = 4'd10;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_BLANK = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_MASK,
    REG_CTRL,
    REG_PHASE
  } reg_kind_e;

  function automatic reg_kind_e decode_addr(input logic [3:0] addr,
                                            input int unsigned channels);
    reg_kind_e kind;
    kind = REG_NONE;
    if ({28'd0, addr} < channels) begin
      kind = REG_DATA;
    end else begin
      case (addr)
        ADDR_MASK:  kind = REG_MASK;
        ADDR_CTRL:  kind = REG_CTRL;
        ADDR_PHASE: kind = REG_PHASE;
        default:    kind = REG_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/audiosystem_blink_timer.sv
// Blink phase generator: free-running divider that toggles phase every DIV cycles.
module audiosystem_blink_timer #(
  parameter int unsigned DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Clear takes priority over a terminal-count toggle in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == TERM) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audiosystem_disp_pio.sv
// Multi-channel Avalon-MM output register bank for display/indicator outputs.
// Optional blink engine (MASK/CTRL/PHASE) built when AUDIOSYSTEM_DISP_PIO_BLINK_EN is defined.
module audiosystem_disp_pio
  import audiosystem_disp_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [CHANNELS*WIDTH-1:0]   out_port
);

  logic                      wr;
  reg_kind_e                 kind;
  logic [WIDTH-1:0]          data_q [CHANNELS];
  logic [CHANNELS-1:0]       blank_sel;
  logic                      blank_lvl;
  logic [CHANNELS*WIDTH-1:0] out_next;
  logic                      unused_wdata;

  assign wr           = chipselect && !write_n;
  assign kind         = decode_addr(address, CHANNELS);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        data_q[c] <= '0;
      end
    end else if (wr && (kind == REG_DATA)) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (address == 4'(c)) begin
          data_q[c] <= writedata[WIDTH-1:0];
        end
      end
    end
  end

`ifdef AUDIOSYSTEM_DISP_PIO_BLINK_EN
  logic [CHANNELS-1:0] mask_q;
  logic [1:0]          ctrl_q;
  logic                ph;
  logic                tmr_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      ctrl_q <= '0;
    end else if (wr) begin
      if (kind == REG_MASK) begin
        mask_q <= writedata[CHANNELS-1:0];
      end
      if (kind == REG_CTRL) begin
        ctrl_q <= writedata[1:0];
      end
    end
  end

  // Clearing EN also clears the timer at the same edge so phase is already 0
  // when the registered EN drops.
  assign tmr_clr = wr && ((kind == REG_PHASE) ||
                          ((kind == REG_CTRL) && !writedata[CTRL_EN]));

  audiosystem_blink_timer #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl_q[CTRL_EN]),
    .clr     (tmr_clr),
    .phase   (ph)
  );

  assign blank_sel = (ctrl_q[CTRL_EN] && ph) ? mask_q : '0;
  assign blank_lvl = ctrl_q[CTRL_BLANK];
`else
  assign blank_sel = '0;
  assign blank_lvl = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (kind)
      REG_DATA: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (address == 4'(c)) begin
            readdata = 32'(data_q[c]);
          end
        end
      end
`ifdef AUDIOSYSTEM_DISP_PIO_BLINK_EN
      REG_MASK:  readdata = 32'(mask_q);
      REG_CTRL:  readdata = 32'(ctrl_q);
      REG_PHASE: readdata = 32'(ph);
`endif
      default:   readdata = '0;
    endcase
  end

  always_comb begin
    out_next = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      out_next[c*WIDTH +: WIDTH] = blank_sel[c] ? {WIDTH{blank_lvl}} : data_q[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= out_next;
    end
  end

endmodule

// File: doc/audiosystem_disp_pio.md
# audiosystem_disp_pio

Parametrised multi-channel Avalon-MM output port bank for the audio system's display/indicator outputs, such as seven-segment digits for the track time. It provides CHANNELS independent WIDTH-bit output registers, each readable and writable by the Nios II over a single slave. An optional hardware blink engine blanks selected channels at a programmable rate without CPU involvement.

## Interface
- WIDTH, 7: bits per channel, 1..32
- CHANNELS, 4: number of output channels, 1..8
- BLINK_DIV, 25000000: clock cycles per blink half-period, ≥2
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, valid with chipselect
- writedata  in  32  write data; bits above the register width are ignored
- readdata  out  32  combinational read data, zero-extended
- out_port  out  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]

## Operation
- Write condition: chipselect && !write_n. Reads have no strobe: readdata = mux(address), zero-latency.
- Register map:
  - 0..CHANNELS-1 DATA[c]: read/write, WIDTH bits.
  - 8 MASK: read/write, CHANNELS bits; a set bit puts that channel under blink control.
  - 9 CTRL: read/write, bit0 EN, bit1 BLANK (the level driven on blanked channels).
  - 10 PHASE: read bit0 = current phase; any write resynchronises the blink engine.
- Unmapped addresses (CHANNELS..7, 11..15): read 0, writes ignored.
- Blink engine:
  - Counter cnt, 0..BLINK_DIV-1, width $clog2(BLINK_DIV). Phase flop ph.
  - EN=1: cnt increments each cycle; at BLINK_DIV-1 it wraps to 0 and ph toggles.
  - EN=0: cnt and ph are synchronously held at 0.
  - A write to PHASE clears cnt and ph to 0. This wins over a terminal-count toggle in the same cycle.
- Output: out_port channel c = (EN && MASK[c] && ph) ? {WIDTH{BLANK}} : DATA[c], registered.
- Reset values: all DATA, MASK, CTRL, cnt and ph = 0; out_port = 0. readdata follows the reset registers and therefore reads 0.

## Timing
- Write sampled at edge T. Registers update at T; readdata reflects the new value after T.
- out_port reflects a DATA/MASK/CTRL write at edge T+1 (one cycle of output latency).
- Phase toggles at the edge where cnt = BLINK_DIV-1. out_port changes at the following edge.
- With EN=1 from reset, the first toggle occurs BLINK_DIV cycles after EN is written. Full blink period = 2*BLINK_DIV cycles.
- A CTRL write clearing EN: ph = 0 at T and out_port unblanked at T+1.
- reset_n assertion mid-operation clears all state immediately, asynchronously. Deassertion is assumed synchronised upstream.

## Configuration
- AUDIOSYSTEM_DISP_PIO_BLINK_EN
  - Defined: blink engine, MASK, CTRL and PHASE are implemented as above.
  - Undefined: no counter or phase logic. Addresses 8..10 read 0 and ignore writes. out_port = registered DATA, still with one cycle of latency.

## Structure
- Package audiosystem_disp_pio_pkg holds:
  - address constants ADDR_MASK=8, ADDR_CTRL=9, ADDR_PHASE=10
  - CTRL bit indices CTRL_EN=0, CTRL_BLANK=1
- Sub-module audiosystem_blink_timer (param DIV; ports clk, reset_n, en, clr; output phase) owns cnt and ph. It is instantiated only under the macro.

## Test plan
Bench config: WIDTH=7, CHANNELS=4, BLINK_DIV=4, macro defined.
- Reset, then read addresses 0..15 -> every read returns 0x0; out_port = 0.
- Write DATA[2]=0xFFFF_FF3F -> readdata at address 2 = 0x3F; out_port[20:14] = 0x3F exactly one cycle later; other channels stay 0.
- Write DATA[0]=0x12, MASK=0x1, CTRL=0x3 -> out_port[6:0] alternates 0x12 / 0x7F every 4 cycles; address 10 reads the matching phase bit.
- While blanked, write CTRL=0x0 -> the next cycle out_port[6:0] = 0x12 and PHASE reads 0. Write to address 5 -> no state change; read of address 5 returns 0.
- Write to PHASE in the same cycle cnt = 3 -> ph = 0, cnt = 0; the next toggle occurs 4 cycles later.
- Assert reset_n mid-blink -> out_port and all registers read 0 immediately, without waiting for a clock. Rebuild without the macro -> addresses 8..10 read 0 and out_port = DATA.
